// File: rtl/bcd_rtc_clock.sv
// -----------------------------------------------------------------------------
// bcd_rtc_clock
// Time-of-day core of the digital clock. A prescaler divides clk_1 down to a
// one-second tick that advances a binary hh:mm:ss count. The count is shown
// as BCD digits in either 24-hour or 12-hour form (with a PM flag). Also
// provides a time-load port, an hh:mm alarm and a day-rollover pulse.
//
// Parameters
//   CLK_DIV   clk_1 cycles per second tick (>= 1)
//   DIV_W     prescaler width, 2**DIV_W >= CLK_DIV
//
// Ports
//   clk_1                     system clock, rising edge
//   rst                       asynchronous active-low reset
//   en                        count enable (0 freezes prescaler and time)
//   mode_12                   1 = 12-hour display, 0 = 24-hour display
//   load, ld_hour/min/sec     one-cycle time load (binary fields)
//   alm_set, alm_hour/min     one-cycle alarm-time capture (binary fields)
//   alm_en                    alarm armed
//   sec_1/sec_2, min_1/min_2,
//   hour_1/hour_2             BCD display digits (ones/tens)
//   pm                        PM flag, 12-hour mode only
//   sec_tick                  high in the cycle the time advances
//   day_pulse                 high in the cycle 23:59:59 rolls to 00:00:00
//   alarm                     registered one-cycle alarm pulse
//   ld_err                    registered one-cycle pulse on a rejected load/set
// -----------------------------------------------------------------------------
module bcd_rtc_clock #(
   parameter int CLK_DIV = 1,
   parameter int DIV_W   = 8
) (
   input  logic       clk_1,
   input  logic       rst,
   input  logic       en,
   input  logic       mode_12,
   input  logic       load,
   input  logic [4:0] ld_hour,
   input  logic [5:0] ld_min,
   input  logic [5:0] ld_sec,
   input  logic       alm_set,
   input  logic [4:0] alm_hour,
   input  logic [5:0] alm_min,
   input  logic       alm_en,
   output logic [3:0] sec_1,
   output logic [2:0] sec_2,
   output logic [3:0] min_1,
   output logic [2:0] min_2,
   output logic [3:0] hour_1,
   output logic [1:0] hour_2,
   output logic       pm,
   output logic       sec_tick,
   output logic       day_pulse,
   output logic       alarm,
   output logic       ld_err
);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   // Binary 0..59 to {tens[2:0], ones[3:0]}.
   function automatic logic [6:0] to_bcd(input logic [5:0] v);
      logic [2:0] t;
      logic [3:0] o;
      if      (v >= 6'd50) begin t = 3'd5; o = 4'(v - 6'd50); end
      else if (v >= 6'd40) begin t = 3'd4; o = 4'(v - 6'd40); end
      else if (v >= 6'd30) begin t = 3'd3; o = 4'(v - 6'd30); end
      else if (v >= 6'd20) begin t = 3'd2; o = 4'(v - 6'd20); end
      else if (v >= 6'd10) begin t = 3'd1; o = 4'(v - 6'd10); end
      else                 begin t = 3'd0; o = v[3:0];         end
      return {t, o};
   endfunction

   logic [4:0]       hour_q, hour_d;
   logic [5:0]       min_q, min_d;
   logic [5:0]       sec_q, sec_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [4:0]       alm_hour_q, alm_hour_d;
   logic [5:0]       alm_min_q, alm_min_d;
   logic             alarm_q, alarm_d;
   logic             ld_err_q, ld_err_d;

   logic ld_valid, alm_valid, end_of_day;
   logic [4:0] disp_hour;
   logic [6:0] sec_bcd, min_bcd;

   assign ld_valid   = (ld_hour <= 5'd23) && (ld_min <= 6'd59) && (ld_sec <= 6'd59);
   assign alm_valid  = (alm_hour <= 5'd23) && (alm_min <= 6'd59);
   assign end_of_day = (hour_q == 5'd23) && (min_q == 6'd59) && (sec_q == 6'd59);

   // Any load request, valid or not, claims the cycle so a tick is never
   // applied on top of (or lost against) a loaded value.
   assign sec_tick  = en && (div_q == DIV_LAST) && !load;
   assign day_pulse = sec_tick && end_of_day;

   always_comb begin
      // NOTE: every variable gets a default before any branch so the
      // combinational block cannot infer a latch on an uncovered path.
      hour_d     = hour_q;
      min_d      = min_q;
      sec_d      = sec_q;
      div_d      = div_q;
      alm_hour_d = alm_hour_q;
      alm_min_d  = alm_min_q;

      if (load && ld_valid) begin
         hour_d = ld_hour;
         min_d  = ld_min;
         sec_d  = ld_sec;
         div_d  = '0;
      end else begin
         if (en) div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
         if (sec_tick) begin
            if (sec_q == 6'd59) begin
               sec_d = '0;
               if (min_q == 6'd59) begin
                  min_d  = '0;
                  hour_d = (hour_q == 5'd23) ? '0 : hour_q + 1'b1;
               end else begin
                  min_d = min_q + 1'b1;
               end
            end else begin
               sec_d = sec_q + 1'b1;
            end
         end
      end

      if (alm_set && alm_valid) begin
         alm_hour_d = alm_hour;
         alm_min_d  = alm_min;
      end

      // Only a tick can fire the alarm; a load landing on the alarm time
      // leaves sec_tick low and so never matches here.
      alarm_d  = sec_tick && alm_en && (hour_d == alm_hour_q) &&
                 (min_d == alm_min_q) && (sec_d == 6'd0);
      ld_err_d = (load && !ld_valid) || (alm_set && !alm_valid);
   end

   // NOTE: state uses non-blocking assignments so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk_1 or negedge rst) begin
      // NOTE: asynchronous reset takes effect immediately, even mid-count,
      // and overrides load, tick and alarm.
      if (!rst) begin
         hour_q     <= '0;
         min_q      <= '0;
         sec_q      <= '0;
         div_q      <= '0;
         alm_hour_q <= '0;
         alm_min_q  <= '0;
         alarm_q    <= 1'b0;
         ld_err_q   <= 1'b0;
      end else begin
         hour_q     <= hour_d;
         min_q      <= min_d;
         sec_q      <= sec_d;
         div_q      <= div_d;
         alm_hour_q <= alm_hour_d;
         alm_min_q  <= alm_min_d;
         alarm_q    <= alarm_d;
         ld_err_q   <= ld_err_d;
      end
   end

   // Display decode. 12-hour form maps 0 -> 12 and 13..23 -> 1..11.
   always_comb begin
      disp_hour = hour_q;
      pm        = 1'b0;
      if (mode_12) begin
         pm = (hour_q >= 5'd12);
         if (hour_q == 5'd0)      disp_hour = 5'd12;
         else if (hour_q > 5'd12) disp_hour = hour_q - 5'd12;
      end
   end

   always_comb begin
      if (disp_hour >= 5'd20) begin
         hour_2 = 2'd2;
         hour_1 = 4'(disp_hour - 5'd20);
      end else if (disp_hour >= 5'd10) begin
         hour_2 = 2'd1;
         hour_1 = 4'(disp_hour - 5'd10);
      end else begin
         hour_2 = 2'd0;
         hour_1 = disp_hour[3:0];
      end
   end

   assign sec_bcd = to_bcd(sec_q);
   assign min_bcd = to_bcd(min_q);
   assign sec_2   = sec_bcd[6:4];
   assign sec_1   = sec_bcd[3:0];
   assign min_2   = min_bcd[6:4];
   assign min_1   = min_bcd[3:0];

   assign alarm  = alarm_q;
   assign ld_err = ld_err_q;

endmodule

// File: tb/tb_bcd_rtc_clock.sv
// -----------------------------------------------------------------------------
// tb_bcd_rtc_clock
// Directed bench for bcd_rtc_clock. Two instances share all inputs: dut_a runs
// with CLK_DIV=1 (tick every enabled cycle), dut_b with CLK_DIV=4 for
// prescaler checks. Inputs change and outputs are sampled 2-3 ns after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_bcd_rtc_clock;

   logic       clk_1 = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       mode_12 = 1'b0;
   logic       load = 1'b0;
   logic [4:0] ld_hour = '0;
   logic [5:0] ld_min = '0;
   logic [5:0] ld_sec = '0;
   logic       alm_set = 1'b0;
   logic [4:0] alm_hour = '0;
   logic [5:0] alm_min = '0;
   logic       alm_en = 1'b0;

   logic [3:0] a_sec_1, a_min_1, a_hour_1, b_sec_1, b_min_1, b_hour_1;
   logic [2:0] a_sec_2, a_min_2, b_sec_2, b_min_2;
   logic [1:0] a_hour_2, b_hour_2;
   logic       a_pm, a_tick, a_day, a_alarm, a_err;
   logic       b_pm, b_tick, b_day, b_alarm, b_err;

   int errors = 0;
   int checks = 0;

   always #5 clk_1 = ~clk_1;

   bcd_rtc_clock #(.CLK_DIV(1), .DIV_W(8)) dut_a (
      .clk_1(clk_1), .rst(rst), .en(en), .mode_12(mode_12), .load(load),
      .ld_hour(ld_hour), .ld_min(ld_min), .ld_sec(ld_sec),
      .alm_set(alm_set), .alm_hour(alm_hour), .alm_min(alm_min), .alm_en(alm_en),
      .sec_1(a_sec_1), .sec_2(a_sec_2), .min_1(a_min_1), .min_2(a_min_2),
      .hour_1(a_hour_1), .hour_2(a_hour_2), .pm(a_pm), .sec_tick(a_tick),
      .day_pulse(a_day), .alarm(a_alarm), .ld_err(a_err)
   );

   bcd_rtc_clock #(.CLK_DIV(4), .DIV_W(8)) dut_b (
      .clk_1(clk_1), .rst(rst), .en(en), .mode_12(mode_12), .load(load),
      .ld_hour(ld_hour), .ld_min(ld_min), .ld_sec(ld_sec),
      .alm_set(alm_set), .alm_hour(alm_hour), .alm_min(alm_min), .alm_en(alm_en),
      .sec_1(b_sec_1), .sec_2(b_sec_2), .min_1(b_min_1), .min_2(b_min_2),
      .hour_1(b_hour_1), .hour_2(b_hour_2), .pm(b_pm), .sec_tick(b_tick),
      .day_pulse(b_day), .alarm(b_alarm), .ld_err(b_err)
   );

   logic [19:0] a_bcd, b_bcd;
   assign a_bcd = {a_hour_2, a_hour_1, a_min_2, a_min_1, a_sec_2, a_sec_1};
   assign b_bcd = {b_hour_2, b_hour_1, b_min_2, b_min_1, b_sec_2, b_sec_1};

   // Expected 24-hour digit vector for hh:mm:ss.
   function automatic logic [19:0] exp_bcd(input int h, input int m, input int s);
      return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
   endfunction

   task automatic cyc();
      @(posedge clk_1);
      #2;
   endtask

   task automatic do_load(input int h, input int m, input int s);
      load = 1'b1; ld_hour = 5'(h); ld_min = 6'(m); ld_sec = 6'(s);
      cyc();
      load = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; mode_12 = 1'b0;
      #3;
      checks++;
      if (a_bcd !== 20'h0) begin errors++; $display("FAIL reset_24h: got %h want %h", a_bcd, 20'h0); end
      checks++;
      if ({a_pm, a_alarm, a_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {a_pm, a_alarm, a_err}); end
      mode_12 = 1'b1;
      #1;
      checks++;
      if ({a_hour_2, a_hour_1, a_pm} !== {2'd1, 4'd2, 1'b0}) begin
         errors++; $display("FAIL reset_12h: got %0d%0d pm=%b want 12 pm=0", a_hour_2, a_hour_1, a_pm);
      end
      mode_12 = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
   endtask

   task automatic test_count();
      en = 1'b1;
      do_load(0, 0, 58);
      checks++;
      if (a_bcd !== exp_bcd(0, 0, 58)) begin errors++; $display("FAIL count_load: got %h want %h", a_bcd, exp_bcd(0, 0, 58)); end
      cyc(); cyc();
      checks++;
      if (a_bcd !== exp_bcd(0, 1, 0)) begin errors++; $display("FAIL count_minute: got %h want %h", a_bcd, exp_bcd(0, 1, 0)); end
      en = 1'b0;
   endtask

   task automatic test_day_rollover();
      en = 1'b0;
      do_load(23, 59, 59);
      en = 1'b1; load = 1'b1;
      #1;
      checks++;
      if ({a_tick, a_day} !== 2'b00) begin errors++; $display("FAIL day_load_suppress: got %b want 00", {a_tick, a_day}); end
      cyc();
      load = 1'b0;
      #1;
      checks++;
      if ({a_tick, a_day} !== 2'b11) begin errors++; $display("FAIL day_pulse_high: got %b want 11", {a_tick, a_day}); end
      cyc();
      checks++;
      if (a_bcd !== exp_bcd(0, 0, 0)) begin errors++; $display("FAIL day_wrap: got %h want %h", a_bcd, exp_bcd(0, 0, 0)); end
      checks++;
      if (a_day !== 1'b0) begin errors++; $display("FAIL day_pulse_once: got %b want 0", a_day); end
      en = 1'b0;
   endtask

   task automatic test_mode_12();
      en = 1'b0; mode_12 = 1'b1;
      do_load(13, 5, 0);
      checks++;
      if ({a_hour_2, a_hour_1, a_pm} !== {2'd0, 4'd1, 1'b1}) begin errors++; $display("FAIL m12_13h: got %0d%0d pm=%b want 01 pm=1", a_hour_2, a_hour_1, a_pm); end
      checks++;
      if ({a_min_2, a_min_1} !== {3'd0, 4'd5}) begin errors++; $display("FAIL m12_min: got %0d%0d want 05", a_min_2, a_min_1); end
      do_load(12, 0, 0);
      checks++;
      if ({a_hour_2, a_hour_1, a_pm} !== {2'd1, 4'd2, 1'b1}) begin errors++; $display("FAIL m12_noon: got %0d%0d pm=%b want 12 pm=1", a_hour_2, a_hour_1, a_pm); end
      do_load(0, 0, 0);
      checks++;
      if ({a_hour_2, a_hour_1, a_pm} !== {2'd1, 4'd2, 1'b0}) begin errors++; $display("FAIL m12_midnight: got %0d%0d pm=%b want 12 pm=0", a_hour_2, a_hour_1, a_pm); end
      do_load(11, 0, 0);
      checks++;
      if ({a_hour_2, a_hour_1, a_pm} !== {2'd1, 4'd1, 1'b0}) begin errors++; $display("FAIL m12_11h: got %0d%0d pm=%b want 11 pm=0", a_hour_2, a_hour_1, a_pm); end
      do_load(23, 0, 0);
      checks++;
      if ({a_hour_2, a_hour_1, a_pm} !== {2'd1, 4'd1, 1'b1}) begin errors++; $display("FAIL m12_23h: got %0d%0d pm=%b want 11 pm=1", a_hour_2, a_hour_1, a_pm); end
      mode_12 = 1'b0;
      #1;
      checks++;
      if ({a_hour_2, a_hour_1, a_pm} !== {2'd2, 4'd3, 1'b0}) begin errors++; $display("FAIL m24_23h: got %0d%0d pm=%b want 23 pm=0", a_hour_2, a_hour_1, a_pm); end
   endtask

   task automatic test_load_err();
      en = 1'b0;
      do_load(10, 20, 30);
      do_load(10, 60, 30);
      checks++;
      if (a_bcd !== exp_bcd(10, 20, 30)) begin errors++; $display("FAIL err_min60_time: got %h want %h", a_bcd, exp_bcd(10, 20, 30)); end
      checks++;
      if (a_err !== 1'b1) begin errors++; $display("FAIL err_min60_pulse: got %b want 1", a_err); end
      cyc();
      checks++;
      if (a_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", a_err); end
      do_load(24, 0, 0);
      checks++;
      if ({a_bcd, a_err} !== {exp_bcd(10, 20, 30), 1'b1}) begin errors++; $display("FAIL err_hour24: got %h/%b want %h/1", a_bcd, a_err, exp_bcd(10, 20, 30)); end
      cyc();
      // invalid load and invalid alarm set in one cycle -> single pulse
      load = 1'b1; ld_hour = 5'd1; ld_min = 6'd0; ld_sec = 6'd60;
      alm_set = 1'b1; alm_hour = 5'd25; alm_min = 6'd0;
      cyc();
      load = 1'b0; alm_set = 1'b0;
      #1;
      checks++;
      if (a_err !== 1'b1) begin errors++; $display("FAIL err_both_pulse: got %b want 1", a_err); end
      cyc();
      checks++;
      if (a_err !== 1'b0) begin errors++; $display("FAIL err_both_single: got %b want 0", a_err); end
      // load in a tick cycle: loaded value shown, no increment
      en = 1'b1;
      cyc();
      do_load(5, 6, 7);
      checks++;
      if (a_bcd !== exp_bcd(5, 6, 7)) begin errors++; $display("FAIL load_beats_tick: got %h want %h", a_bcd, exp_bcd(5, 6, 7)); end
      en = 1'b0;
   endtask

   task automatic test_alarm();
      en = 1'b0;
      alm_set = 1'b1; alm_hour = 5'd7; alm_min = 6'd30;
      cyc();
      alm_set = 1'b0; alm_en = 1'b1;
      do_load(7, 29, 59);
      checks++;
      if (a_alarm !== 1'b0) begin errors++; $display("FAIL alarm_early: got %b want 0", a_alarm); end
      en = 1'b1;
      cyc();
      en = 1'b0;
      checks++;
      if ({a_bcd, a_alarm} !== {exp_bcd(7, 30, 0), 1'b1}) begin errors++; $display("FAIL alarm_fire: got %h/%b want %h/1", a_bcd, a_alarm, exp_bcd(7, 30, 0)); end
      cyc();
      checks++;
      if (a_alarm !== 1'b0) begin errors++; $display("FAIL alarm_one_cycle: got %b want 0", a_alarm); end
      alm_en = 1'b0;
      do_load(7, 29, 59);
      en = 1'b1;
      cyc();
      en = 1'b0;
      checks++;
      if (a_alarm !== 1'b0) begin errors++; $display("FAIL alarm_disarmed: got %b want 0", a_alarm); end
      alm_en = 1'b1;
      do_load(7, 30, 0);
      cyc();
      checks++;
      if (a_alarm !== 1'b0) begin errors++; $display("FAIL alarm_load_match: got %b want 0", a_alarm); end
      // rejected alarm set keeps 07:30 and pulses ld_err
      alm_set = 1'b1; alm_hour = 5'd8; alm_min = 6'd61;
      cyc();
      alm_set = 1'b0;
      #1;
      checks++;
      if (a_err !== 1'b1) begin errors++; $display("FAIL alm_set_err: got %b want 1", a_err); end
      do_load(7, 29, 59);
      en = 1'b1;
      cyc();
      en = 1'b0;
      checks++;
      if (a_alarm !== 1'b1) begin errors++; $display("FAIL alarm_kept: got %b want 1", a_alarm); end
      alm_en = 1'b0;
   endtask

   task automatic test_prescaler();
      logic [6:0] en_pat, tick_pat;
      en = 1'b0;
      do_load(0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         en = 1'b1;
         #1;
         checks++;
         if (b_tick !== (i == 3)) begin errors++; $display("FAIL div4_tick[%0d]: got %b want %b", i, b_tick, (i == 3)); end
         cyc();
      end
      checks++;
      if (b_bcd !== exp_bcd(0, 0, 1)) begin errors++; $display("FAIL div4_time: got %h want %h", b_bcd, exp_bcd(0, 0, 1)); end
      // three disabled cycles in the middle delay the tick by three cycles
      en_pat   = 7'b1100011;   // applied LSB first
      tick_pat = 7'b1000000;
      for (int i = 0; i < 7; i++) begin
         en = en_pat[i];
         #1;
         checks++;
         if (b_tick !== tick_pat[i]) begin errors++; $display("FAIL div4_hold[%0d]: got %b want %b", i, b_tick, tick_pat[i]); end
         cyc();
      end
      checks++;
      if (b_bcd !== exp_bcd(0, 0, 2)) begin errors++; $display("FAIL div4_hold_time: got %h want %h", b_bcd, exp_bcd(0, 0, 2)); end
      // reset mid-count: immediate clear, prescaler restarts from 0
      en = 1'b1;
      cyc(); cyc();
      rst = 1'b0;
      #1;
      checks++;
      if (b_bcd !== 20'h0) begin errors++; $display("FAIL rst_mid_time: got %h want 0", b_bcd); end
      cyc();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (b_tick !== (i == 3)) begin errors++; $display("FAIL rst_restart[%0d]: got %b want %b", i, b_tick, (i == 3)); end
         cyc();
      end
      en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count();
      test_day_rollover();
      test_mode_12();
      test_load_err();
      test_alarm();
      test_prescaler();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
